// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster timing generator.
package vga_timing_pkg;

  // Default 640x480@60 geometry (pixels / lines).
  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int H_TOTAL  = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 800
  localparam int V_TOTAL  = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 525
  localparam int HS_START = DEF_H_VIS + DEF_H_FP;                          // 656
  localparam int HS_END   = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC - 1;         // 751
  localparam int VS_START = DEF_V_VIS + DEF_V_FP;                          // 490
  localparam int VS_END   = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC - 1;         // 491

  typedef enum logic {
    START = 1'b0,
    RUN   = 1'b1
  } ctrl_state_t;

  // Inclusive range test on a 10-bit coordinate.
  function automatic logic in_span(input logic [9:0] v,
                                   input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-N 10-bit axis counter. Exposes the registered count, the
// combinational next count (so downstream decode can be registered in
// step with the count) and a registered "at terminal count" flag.
module vga_axis_counter #(
  parameter int N = 800
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  output logic [9:0] cnt_o,
  output logic [9:0] nxt_o,
  output logic       wrap_o
);

  localparam logic [9:0] LAST = 10'(N - 1);

  logic [9:0] cnt_q, cnt_d;
  logic       wrap_q, wrap_d;

  // Next count; >= so an upset out-of-range value folds back to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = (cnt_q >= LAST) ? 10'd0 : cnt_q + 10'd1;
    wrap_d = (cnt_d >= LAST);
  end

  // Count and terminal flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= 10'd0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign nxt_o  = cnt_d;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: sync, coordinates, active-video flag and
// line/frame strobes, all registered against the same pixel.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VIS    = DEF_H_VIS,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_VIS    = DEF_V_VIS,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_NEG = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       line_tick,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  localparam int         H_TOT     = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int         V_TOT     = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] HS_LO     = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_HI     = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO     = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_HI     = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_VIS_W   = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W   = 10'(V_VIS);
  localparam logic       SYNC_IDLE = (SYNC_NEG != 0);

  ctrl_state_t state_q, state_d;
  logic        run;
  logic [9:0]  h_cnt, h_nxt, v_cnt, v_nxt;
  logic        h_wrap, v_wrap;

  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       on_q, on_d, lt_q, lt_d, ft_q, ft_d;
  logic [7:0] fc_q, fc_d;

  // Controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= START;
    else       state_q <= state_d;
  end

  // START lasts exactly one edge; counters hold at (0,0) while in it.
  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      START:   state_d = RUN;
      RUN:     run     = 1'b1;
      default: state_d = START;
    endcase
  end

  vga_axis_counter #(.N(H_TOT)) u_h (
    .clk_i (clk),
    .rst_i (reset),
    .inc_i (run),
    .cnt_o (h_cnt),
    .nxt_o (h_nxt),
    .wrap_o(h_wrap)
  );

  vga_axis_counter #(.N(V_TOT)) u_v (
    .clk_i (clk),
    .rst_i (reset),
    .inc_i (run & h_wrap),
    .cnt_o (v_cnt),
    .nxt_o (v_nxt),
    .wrap_o(v_wrap)
  );

  // Decode from the next coordinates so outputs align with hpos/vpos.
  always_comb begin
    hsync_d = in_span(h_nxt, HS_LO, HS_HI) ^ SYNC_IDLE;
    vsync_d = in_span(v_nxt, VS_LO, VS_HI) ^ SYNC_IDLE;
    on_d    = (h_nxt < H_VIS_W) && (v_nxt < V_VIS_W);
    lt_d    = (h_nxt == 10'd0);
    ft_d    = lt_d && (v_nxt == 10'd0);
    // Last pixel of the last line rolling over; the START tick never counts.
    fc_d    = fc_q + {7'd0, run & h_wrap & v_wrap};
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q <= SYNC_IDLE;
      vsync_q <= SYNC_IDLE;
      on_q    <= 1'b0;
      lt_q    <= 1'b0;
      ft_q    <= 1'b0;
      fc_q    <= 8'd0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      on_q    <= on_d;
      lt_q    <= lt_d;
      ft_q    <= ft_d;
      fc_q    <= fc_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = on_q;
  assign hpos        = h_cnt;
  assign vpos        = v_cnt;
  assign line_tick   = lt_q;
  assign frame_tick  = ft_q;
  assign frame_count = fc_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the display pipeline, directly upstream of the three-body renderer top.
- Produces 640x480@60 Hz sync, pixel coordinates, the active-video flag and per-frame/per-line strobes from a 25.175 MHz pixel clock.
- The renderer consumes the signals as follows:
  - hpos/vpos for hit tests
  - display_on for colour blanking
  - frame_tick for physics updates
  - hsync/vsync for the TinyVGA PMOD
- Every output is registered and aligned to the same pixel, with zero skew between sync and coordinates.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_NEG, 1, 1 = sync pulses active-low (VGA 640x480 standard); 0 = active-high

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- hsync  out  1  horizontal sync, polarity per SYNC_NEG
- vsync  out  1  vertical sync, polarity per SYNC_NEG
- display_on  out  1  high while hpos<H_VIS and vpos<V_VIS
- hpos  out  10  pixel column, 0..H_TOTAL-1
- vpos  out  10  line number, 0..V_TOTAL-1
- line_tick  out  1  one-cycle pulse when hpos==0 (every line)
- frame_tick  out  1  one-cycle pulse when hpos==0 and vpos==0
- frame_count  out  8  frames started since reset, wraps 255->0

Behaviour:
- Derived constants: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP = 525.
- Async reset (reset=1), applied immediately and held:
  - hpos=0, vpos=0, display_on=0, line_tick=0, frame_tick=0, frame_count=0
  - hsync and vsync at their inactive level (1 when SYNC_NEG=1)
  - controller enters START.
- Two-state controller:
  - START -> RUN on the first clk edge after reset deasserts.
  - On that edge the counters hold at (0,0), and display_on=1, line_tick=1, frame_tick=1 are driven, so frame 0 gets a full tick.
  - RUN persists until reset.
- In RUN, each clk edge:
  - if hpos==H_TOTAL-1: hpos<=0, and vpos<=(vpos==V_TOTAL-1 ? 0 : vpos+1)
  - otherwise hpos<=hpos+1 and vpos holds.
- Every decoded output is computed from the next counter value and registered, so it describes the same pixel as hpos/vpos in the same cycle:
  - hsync active for hpos in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656,751]
  - vsync active for vpos in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] = [490,491], for the whole of each of those lines
  - display_on = (hpos<640)&&(vpos<480)
  - line_tick = (hpos==0); frame_tick = (hpos==0)&&(vpos==0)
- frame_count increments in the same cycle frame_tick asserts. The START tick does not increment it, so frame_count=0 during frame 0 and 1 during frame 1. Wraps modulo 256.
- Widths and wrap: counters are 10-bit unsigned and never exceed H_TOTAL-1/V_TOTAL-1. No illegal value is reachable; any out-of-range value (e.g. SEU) wraps to 0 on the next wrap comparison using >=, not ==.
- Reset mid-frame: all outputs return to reset values asynchronously. Timing restarts from START with no partial frame_tick.
- Periods:
  - line = 800 cycles
  - frame = 420000 cycles
  - frame_tick period = 420000 cycles exactly, including the START frame.

Decomposition:
- Package vga_timing_pkg holds:
  - the default H_/V_ constants
  - H_TOTAL/V_TOTAL and the sync start/end localparams
  - a 1-bit ctrl_state_t enum {START, RUN}.
- One sub-module, vga_axis_counter: a parameterised modulo-N 10-bit counter with an inc enable and a registered wrap output.
  - Instantiated for H (inc=RUN).
  - Instantiated for V (inc=H wrap).

Test Plan:
1. Reset held 10 cycles, then released:
   - during reset: hsync=vsync=1, display_on=0, ticks=0, hpos=vpos=0
   - first edge after release: hpos=0, vpos=0, frame_tick=1, line_tick=1, display_on=1, frame_count=0.
2. Run one line:
   - hpos 639->640 drops display_on
   - hsync goes low at hpos=656 and high at 752
   - hpos=799 is followed by hpos=0, vpos=1, line_tick=1.
3. Run to end of frame:
   - vpos=480 keeps display_on=0 all line
   - vsync low exactly for vpos 490..491
   - after (799,524) comes (0,0), with frame_tick=1 and frame_count=1.
4. Measure over 3 frames:
   - frame_tick spacing = 420000 cycles
   - line_tick spacing = 800 cycles
   - exactly 525 line_ticks per frame_tick.
5. Assert reset asynchronously at (hpos=300, vpos=200) mid-cycle:
   - outputs go to reset values before the next clk edge
   - after release the sequence of scenario 1 repeats and frame_count=0.
6. Force 256 frames (or preload frame_count=255):
   - the next frame_tick wraps frame_count to 0
   - SYNC_NEG=0 build: hsync=1 only for hpos 656..751.
